// File: rtl/victim_alloc_pkg.sv
// Shared types and constants for the victim way allocator.
package victim_alloc_pkg;

  // Width of the retry counter; wide enough for MAX_RETRY up to 15.
  localparam int RETRY_W = 4;

  // Allocator FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PICK = 2'd1,
    RESP = 2'd2
  } alloc_state_e;

endpackage

// File: rtl/victim_prio_enc.sv
// Lowest-index priority encoder: returns the index and one-hot of the lowest
// set bit of req, and flags when no bit is set.
module victim_prio_enc #(
  parameter int NB_WAYS = 4,
  parameter int WAY_W   = $clog2(NB_WAYS)
) (
  input  logic [NB_WAYS-1:0] req,
  output logic [WAY_W-1:0]   idx,
  output logic [NB_WAYS-1:0] oh,
  output logic               empty
);

  // below[i] is set when any request bit with index < i is set.
  logic [NB_WAYS:0] below;

  assign below[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < NB_WAYS; gi++) begin : g_chain
      assign below[gi+1] = below[gi] | req[gi];
      assign oh[gi]      = req[gi] & ~below[gi];
    end
  endgenerate

  assign empty = ~below[NB_WAYS];

  // Fold the one-hot winner back into a binary index.
  always_comb begin
    idx = '0;
    for (int i = 0; i < NB_WAYS; i++) begin
      if (oh[i]) begin
        idx = idx | WAY_W'(i);
      end
    end
  end

endmodule

// File: rtl/victim_way_alloc.sv
// Victim way allocator: picks a replacement way for a cache miss, preferring
// an invalid way, then the LFSR random way, then after MAX_RETRY rejected
// draws the lowest eligible way. Reports failure when every way is locked.
// Optional statistics counters are enabled by VICTIM_WAY_ALLOC_STATS_EN.
module victim_way_alloc
  import victim_alloc_pkg::*;
#(
  parameter int NB_WAYS   = 4,
  parameter int WAY_W     = $clog2(NB_WAYS),
  parameter int MAX_RETRY = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [NB_WAYS-1:0] way_valid_i,
  input  logic [NB_WAYS-1:0] way_lock_i,
  input  logic [WAY_W-1:0]   rnd_bin_i,
  output logic               rnd_en_o,
  output logic               victim_valid_o,
  input  logic               victim_ready_i,
  output logic [WAY_W-1:0]   victim_bin_o,
  output logic [NB_WAYS-1:0] victim_oh_o,
  output logic               victim_evict_o,
  output logic               victim_fail_o
`ifdef VICTIM_WAY_ALLOC_STATS_EN
  ,
  output logic [15:0]        evict_cnt_o,
  output logic [15:0]        fail_cnt_o
`endif
);

  localparam logic [RETRY_W-1:0] MAX_RETRY_C = RETRY_W'(MAX_RETRY);

  alloc_state_e        state_q, state_next;
  logic [NB_WAYS-1:0]  valid_q, lock_q;
  logic [RETRY_W-1:0]  retry_q, retry_next;
  logic [WAY_W-1:0]    bin_q, bin_next;
  logic [NB_WAYS-1:0]  oh_q, oh_next;
  logic                evict_q, evict_next;
  logic                fail_q, fail_next;
  logic                capture;
  logic                rnd_en;

  logic [NB_WAYS-1:0]  elig, inv;
  logic [WAY_W-1:0]    inv_idx, elig_idx;
  logic [NB_WAYS-1:0]  inv_oh, elig_oh;
  logic                inv_empty, elig_empty;
  logic [NB_WAYS-1:0]  rnd_oh;
  logic                rnd_hit;

  assign elig = ~lock_q;
  assign inv  = elig & ~valid_q;

  victim_prio_enc #(.NB_WAYS(NB_WAYS), .WAY_W(WAY_W)) u_inv_enc (
    .req   (inv),
    .idx   (inv_idx),
    .oh    (inv_oh),
    .empty (inv_empty)
  );

  victim_prio_enc #(.NB_WAYS(NB_WAYS), .WAY_W(WAY_W)) u_elig_enc (
    .req   (elig),
    .idx   (elig_idx),
    .oh    (elig_oh),
    .empty (elig_empty)
  );

  // Decode the random way so it can be tested against the eligible mask and
  // reused directly as the registered one-hot result.
  generate
    for (genvar gi = 0; gi < NB_WAYS; gi++) begin : g_rnd_dec
      assign rnd_oh[gi] = (rnd_bin_i == WAY_W'(gi));
    end
  endgenerate

  assign rnd_hit = |(rnd_oh & elig);

  // Next-state, victim selection and LFSR enable.
  always_comb begin
    state_next = state_q;
    retry_next = retry_q;
    bin_next   = bin_q;
    oh_next    = oh_q;
    evict_next = evict_q;
    fail_next  = fail_q;
    capture    = 1'b0;
    rnd_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          capture    = 1'b1;
          retry_next = '0;
          state_next = PICK;
        end
      end
      PICK: begin
        if (elig_empty) begin
          // Every way locked: report failure without touching the LFSR.
          bin_next   = '0;
          oh_next    = '0;
          evict_next = 1'b0;
          fail_next  = 1'b1;
          state_next = RESP;
        end else if (!inv_empty) begin
          // A free way needs no eviction and leaves the LFSR untouched.
          bin_next   = inv_idx;
          oh_next    = inv_oh;
          evict_next = 1'b0;
          fail_next  = 1'b0;
          state_next = RESP;
        end else if (rnd_hit) begin
          bin_next   = rnd_bin_i;
          oh_next    = rnd_oh;
          evict_next = 1'b1;
          fail_next  = 1'b0;
          rnd_en     = 1'b1;
          state_next = RESP;
        end else if (retry_q < MAX_RETRY_C) begin
          // Drawn way is locked: advance the LFSR and look again next cycle.
          rnd_en     = 1'b1;
          retry_next = retry_q + 4'd1;
        end else begin
          // Out of retries: fall back to the lowest eligible way.
          bin_next   = elig_idx;
          oh_next    = elig_oh;
          evict_next = 1'b1;
          fail_next  = 1'b0;
          rnd_en     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (victim_ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, captured masks, retry count and the registered victim result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= '0;
      lock_q  <= '0;
      retry_q <= '0;
      bin_q   <= '0;
      oh_q    <= '0;
      evict_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_next;
      retry_q <= retry_next;
      bin_q   <= bin_next;
      oh_q    <= oh_next;
      evict_q <= evict_next;
      fail_q  <= fail_next;
      if (capture) begin
        valid_q <= way_valid_i;
        lock_q  <= way_lock_i;
      end
    end
  end

  assign req_ready_o    = (state_q == IDLE);
  assign victim_valid_o = (state_q == RESP);
  assign rnd_en_o       = rnd_en;
  assign victim_bin_o   = bin_q;
  assign victim_oh_o    = oh_q;
  assign victim_evict_o = evict_q;
  assign victim_fail_o  = fail_q;

`ifdef VICTIM_WAY_ALLOC_STATS_EN
  logic        resp_hs;
  logic [15:0] evict_cnt_q, fail_cnt_q;

  assign resp_hs = victim_valid_o & victim_ready_i;

  // Saturating counts of evicting and failed allocations, taken at handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evict_cnt_q <= '0;
      fail_cnt_q  <= '0;
    end else if (resp_hs) begin
      if (evict_q && (evict_cnt_q != 16'hFFFF)) begin
        evict_cnt_q <= evict_cnt_q + 16'd1;
      end
      if (fail_q && (fail_cnt_q != 16'hFFFF)) begin
        fail_cnt_q <= fail_cnt_q + 16'd1;
      end
    end
  end

  assign evict_cnt_o = evict_cnt_q;
  assign fail_cnt_o  = fail_cnt_q;
`endif

endmodule

// File: tb/tb_victim_way_alloc.sv
// Directed testbench for victim_way_alloc (NB_WAYS=4, MAX_RETRY=3).
module tb_victim_way_alloc;

  localparam int NB_WAYS = 4;
  localparam int WAY_W   = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               req_valid_i = 1'b0;
  logic               req_ready_o;
  logic [NB_WAYS-1:0] way_valid_i = '0;
  logic [NB_WAYS-1:0] way_lock_i = '0;
  logic [WAY_W-1:0]   rnd_bin_i = '0;
  logic               rnd_en_o;
  logic               victim_valid_o;
  logic               victim_ready_i = 1'b0;
  logic [WAY_W-1:0]   victim_bin_o;
  logic [NB_WAYS-1:0] victim_oh_o;
  logic               victim_evict_o;
  logic               victim_fail_o;
`ifdef VICTIM_WAY_ALLOC_STATS_EN
  logic [15:0]        evict_cnt_o;
  logic [15:0]        fail_cnt_o;
`endif

  victim_way_alloc #(.NB_WAYS(NB_WAYS), .WAY_W(WAY_W), .MAX_RETRY(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .way_valid_i    (way_valid_i),
    .way_lock_i     (way_lock_i),
    .rnd_bin_i      (rnd_bin_i),
    .rnd_en_o       (rnd_en_o),
    .victim_valid_o (victim_valid_o),
    .victim_ready_i (victim_ready_i),
    .victim_bin_o   (victim_bin_o),
    .victim_oh_o    (victim_oh_o),
    .victim_evict_o (victim_evict_o),
    .victim_fail_o  (victim_fail_o)
`ifdef VICTIM_WAY_ALLOC_STATS_EN
    ,
    .evict_cnt_o    (evict_cnt_o),
    .fail_cnt_o     (fail_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int rnd_cnt = 0;
  int bad_rnd = 0;

  // Count LFSR pulses; flag any pulse seen while idle or responding.
  always @(posedge clk) begin
    if (rnd_en_o) begin
      rnd_cnt <= rnd_cnt + 1;
      if (req_ready_o || victim_valid_o) bad_rnd <= bad_rnd + 1;
    end
  end

  logic [WAY_W-1:0] seq [4];
  int base;
  int lat;
  logic [9:0] snap_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait for the result; lat counts the accept cycle.
  // The random input follows seq, advanced by the number of pulses consumed.
  task automatic run_req(input logic [3:0] v, input logic [3:0] l, output int l_out);
    int k;
    req_valid_i = 1'b1;
    way_valid_i = v;
    way_lock_i  = l;
    rnd_bin_i   = seq[0];
    base        = rnd_cnt;
    step();
    req_valid_i = 1'b0;
    way_valid_i = ~v;
    way_lock_i  = ~l;
    l_out = 1;
    forever begin
      k = rnd_cnt - base;
      if (k > 3) k = 3;
      rnd_bin_i = seq[k];
      #1;
      if (victim_valid_o || l_out >= 20) break;
      step();
      l_out++;
    end
    check("resp_seen", {31'd0, victim_valid_o}, 32'd1);
  endtask

  task automatic handshake();
    victim_ready_i = 1'b1;
    step();
    victim_ready_i = 1'b0;
    check("hs_idle_ready", {31'd0, req_ready_o}, 32'd1);
    check("hs_idle_valid", {31'd0, victim_valid_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, held in reset and after release.
    step();
    step();
    check("rst_ready", {31'd0, req_ready_o}, 32'd1);
    check("rst_valid", {31'd0, victim_valid_o}, 32'd0);
    check("rst_rnd_en", {31'd0, rnd_en_o}, 32'd0);
    check("rst_outs", {24'd0, victim_bin_o, victim_oh_o, victim_evict_o, victim_fail_o}, 32'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_ready", {31'd0, req_ready_o}, 32'd1);

    // 1: invalid way 2 chosen, no LFSR use; masks changed after capture.
    seq[0] = 2'd1; seq[1] = 2'd1; seq[2] = 2'd1; seq[3] = 2'd1;
    run_req(4'b1011, 4'b0000, lat);
    $display("txn1 bin=%0d oh=%b evict=%b lat=%0d", victim_bin_o, victim_oh_o, victim_evict_o, lat);
    check("t1_lat", lat, 32'd2);
    check("t1_bin", {30'd0, victim_bin_o}, 32'd2);
    check("t1_oh", {28'd0, victim_oh_o}, 32'b0100);
    check("t1_evict", {31'd0, victim_evict_o}, 32'd0);
    check("t1_fail", {31'd0, victim_fail_o}, 32'd0);
    check("t1_ready_busy", {31'd0, req_ready_o}, 32'd0);
    check("t1_pulses", rnd_cnt - base, 32'd0);
    handshake();

    // 2: all valid, random way 3 accepted; ready held high throughout.
    victim_ready_i = 1'b1;
    seq[0] = 2'd3; seq[1] = 2'd0; seq[2] = 2'd0; seq[3] = 2'd0;
    run_req(4'hF, 4'h0, lat);
    $display("txn2 bin=%0d oh=%b evict=%b lat=%0d", victim_bin_o, victim_oh_o, victim_evict_o, lat);
    check("t2_lat", lat, 32'd2);
    check("t2_bin", {30'd0, victim_bin_o}, 32'd3);
    check("t2_oh", {28'd0, victim_oh_o}, 32'b1000);
    check("t2_evict", {31'd0, victim_evict_o}, 32'd1);
    check("t2_pulses", rnd_cnt - base, 32'd1);
    step();
    victim_ready_i = 1'b0;
    check("t2_idle", {31'd0, req_ready_o}, 32'd1);

    // 3: locks on 1,2; draws 1,2,0 -> two retries then way 0.
    seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd0; seq[3] = 2'd0;
    run_req(4'hF, 4'b0110, lat);
    $display("txn3 bin=%0d oh=%b evict=%b lat=%0d", victim_bin_o, victim_oh_o, victim_evict_o, lat);
    check("t3_lat", lat, 32'd4);
    check("t3_bin", {30'd0, victim_bin_o}, 32'd0);
    check("t3_oh", {28'd0, victim_oh_o}, 32'b0001);
    check("t3_evict", {31'd0, victim_evict_o}, 32'd1);
    check("t3_pulses", rnd_cnt - base, 32'd3);
    handshake();

    // 4: only way 0 unlocked, random stuck at 2 -> 3 retries then fallback.
    seq[0] = 2'd2; seq[1] = 2'd2; seq[2] = 2'd2; seq[3] = 2'd2;
    run_req(4'hF, 4'b1110, lat);
    $display("txn4 bin=%0d oh=%b evict=%b lat=%0d", victim_bin_o, victim_oh_o, victim_evict_o, lat);
    check("t4_lat", lat, 32'd5);
    check("t4_bin", {30'd0, victim_bin_o}, 32'd0);
    check("t4_oh", {28'd0, victim_oh_o}, 32'b0001);
    check("t4_evict", {31'd0, victim_evict_o}, 32'd1);
    check("t4_fail", {31'd0, victim_fail_o}, 32'd0);
    check("t4_pulses", rnd_cnt - base, 32'd4);
    handshake();

    // 5: all locked -> fail, held stable while ready is low.
    seq[0] = 2'd1; seq[1] = 2'd1; seq[2] = 2'd1; seq[3] = 2'd1;
    run_req(4'h3, 4'hF, lat);
    $display("txn5 fail=%b oh=%b lat=%0d", victim_fail_o, victim_oh_o, lat);
    check("t5_lat", lat, 32'd2);
    check("t5_fail", {31'd0, victim_fail_o}, 32'd1);
    check("t5_oh", {28'd0, victim_oh_o}, 32'd0);
    check("t5_bin", {30'd0, victim_bin_o}, 32'd0);
    check("t5_evict", {31'd0, victim_evict_o}, 32'd0);
    check("t5_pulses", rnd_cnt - base, 32'd0);
    snap_exp = {1'b1, 1'b0, 1'b1, 4'b0000, 2'b00, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_hold", {22'd0, victim_valid_o, req_ready_o, victim_fail_o,
                        victim_oh_o, victim_bin_o, victim_evict_o}, {22'd0, snap_exp});
    end
    handshake();

`ifdef VICTIM_WAY_ALLOC_STATS_EN
    check("stats_evict", {16'd0, evict_cnt_o}, 32'd3);
    check("stats_fail", {16'd0, fail_cnt_o}, 32'd1);
`endif

    // 6: asynchronous reset in the middle of a PICK retry.
    seq[0] = 2'd2; seq[1] = 2'd2; seq[2] = 2'd2; seq[3] = 2'd2;
    req_valid_i = 1'b1;
    way_valid_i = 4'hF;
    way_lock_i  = 4'b1110;
    rnd_bin_i   = 2'd2;
    step();
    req_valid_i = 1'b0;
    step();
    #1;
    rst_n = 1'b0;
    #1;
    $display("txn6 reset mid-pick ready=%b valid=%b", req_ready_o, victim_valid_o);
    check("t6_rst_valid", {31'd0, victim_valid_o}, 32'd0);
    check("t6_rst_ready", {31'd0, req_ready_o}, 32'd1);
    check("t6_rst_rnd_en", {31'd0, rnd_en_o}, 32'd0);
    base = rnd_cnt;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    check("t6_no_pulses", rnd_cnt - base, 32'd0);
    check("t6_no_victim", {31'd0, victim_valid_o}, 32'd0);
`ifdef VICTIM_WAY_ALLOC_STATS_EN
    check("stats_rst_evict", {16'd0, evict_cnt_o}, 32'd0);
    check("stats_rst_fail", {16'd0, fail_cnt_o}, 32'd0);
`endif
    run_req(4'b0111, 4'h0, lat);
    $display("txn7 bin=%0d oh=%b evict=%b lat=%0d", victim_bin_o, victim_oh_o, victim_evict_o, lat);
    check("t7_lat", lat, 32'd2);
    check("t7_bin", {30'd0, victim_bin_o}, 32'd3);
    check("t7_oh", {28'd0, victim_oh_o}, 32'b1000);
    check("t7_evict", {31'd0, victim_evict_o}, 32'd0);
    check("t7_pulses", rnd_cnt - base, 32'd0);
    handshake();

    check("rnd_en_outside_pick", bad_rnd, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
